// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: funct3 codes, LSU FSM state encoding and default memory size.
package riscv_mem_pkg;
    localparam int MEM_BYTES_DEF = 256;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_RMW_RD, S_RMW_WR, S_RESP} state_t;
endpackage

// File: rtl/lsu_mem_initiator_if.sv
// lsu_mem_initiator_if: pipeline request/response and 64-bit data-memory port.
interface lsu_mem_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic        MemRead;
    logic        MemWrite;
    logic [63:0] Read_Data;
    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, Read_Data,
        input  req_ready, resp_valid, resp_rdata, resp_fault, Mem_Addr, Write_Data, MemRead, MemWrite
    );
    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, Read_Data,
        output req_ready, resp_valid, resp_rdata, resp_fault, Mem_Addr, Write_Data, MemRead, MemWrite
    );
endinterface

// File: rtl/lsu_data_align.sv
// lsu_data_align: load extract/extend and sub-doubleword store merge.
module lsu_data_align
    import riscv_mem_pkg::*;
(
    input  logic [63:0] data,
    input  logic [63:0] old,
    input  logic [63:0] wdata,
    input  logic [2:0]  funct3,
    output logic [63:0] rdata,
    output logic [63:0] merged
);
    always_comb begin
        rdata = '0;
        case (funct3)
            F3_B:  rdata = {{56{data[7]}}, data[7:0]};
            F3_H:  rdata = {{48{data[15]}}, data[15:0]};
            F3_W:  rdata = {{32{data[31]}}, data[31:0]};
            F3_D:  rdata = data;
            F3_BU: rdata = {56'd0, data[7:0]};
            F3_HU: rdata = {48'd0, data[15:0]};
            F3_WU: rdata = {32'd0, data[31:0]};
            default: rdata = '0;
        endcase
        merged = funct3[1:0] == 2'b00 ? {old[63:8], wdata[7:0]} :
                 funct3[1:0] == 2'b01 ? {old[63:16], wdata[15:0]} :
                 funct3[1:0] == 2'b10 ? {old[63:32], wdata[31:0]} : wdata;
    end
endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: sequences loads, stores (RMW for sub-doubleword) and range/code faults
// onto a 64-bit byte-addressed data memory port.
module lsu_mem_initiator
    import riscv_mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input logic clk,
    input logic rst_n,
    lsu_mem_initiator_if.slave bus
);
    // Comparing against MEM_BYTES-7 avoids the wrap that addr+7 would suffer near 2^64.
    localparam logic [63:0] LIMIT = 64'(MEM_BYTES - 7);
    state_t state, next;
    logic [2:0]  f3_q;
    logic [63:0] addr_q, wdata_q, rdata_q, load_data, merged;
    logic accept, fault, rd, wr;
    assign accept = bus.req_valid && state == S_IDLE;
    assign fault  = bus.req_funct3 == 3'b111 || (bus.req_write && bus.req_funct3[2]) || bus.req_addr >= LIMIT;
    assign rd = state == S_RD || state == S_RMW_RD;
    assign wr = state == S_WR || state == S_RMW_WR;
    assign bus.req_ready  = state == S_IDLE;
    assign bus.resp_valid = state == S_RESP;
    assign bus.MemRead    = rd;
    assign bus.MemWrite   = wr;
    assign bus.Mem_Addr   = rd || wr ? addr_q : '0;
    assign bus.Write_Data = state == S_WR ? wdata_q : state == S_RMW_WR ? merged : '0;
    always_comb begin
        next = state;
        case (state)
            S_IDLE:   if (accept) next = fault ? S_RESP : !bus.req_write ? S_RD :
                                         bus.req_funct3 == F3_D ? S_WR : S_RMW_RD;
            S_RD:     next = S_RESP;
            S_WR:     next = S_RESP;
            S_RMW_RD: next = S_RMW_WR;
            S_RMW_WR: next = S_RESP;
            default:  next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            f3_q           <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            bus.resp_rdata <= '0;
            bus.resp_fault <= 1'b0;
        end else begin
            state <= next;
            if (accept) begin
                f3_q           <= bus.req_funct3;
                addr_q         <= bus.req_addr;
                wdata_q        <= bus.req_wdata;
                bus.resp_fault <= fault;
            end else if (state == S_RESP) begin
                bus.resp_fault <= 1'b0;
            end
            if (rd) rdata_q <= bus.Read_Data;
            bus.resp_rdata <= state == S_RD ? load_data : '0;
        end
    end
    lsu_data_align u_align (
        .data   (bus.Read_Data),
        .old    (rdata_q),
        .wdata  (wdata_q),
        .funct3 (f3_q),
        .rdata  (load_data),
        .merged (merged)
    );
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: directed load/store/fault/reset-abort sequence against a byte memory model.
module tb_lsu_mem_initiator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b1;
    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;
    int lat, rd_cyc, wr_cyc;
    logic [63:0] rdata, wd, ma;
    logic flt;
    lsu_mem_initiator_if bi ();
    lsu_mem_initiator #(.MEM_BYTES(256)) dut (.clk(clk), .rst_n(rst_n), .bus(bi));
    always #5 clk = ~clk;
    always_comb begin
        bi.Read_Data = '0;
        for (int i = 0; i < 8; i++)
            if (bi.Mem_Addr + 64'(i) < 64'd256) bi.Read_Data[8*i +: 8] = mem[8'(bi.Mem_Addr + 64'(i))];
    end
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[0] <= 8'd3;
            mem[8] <= 8'd1;
            mem[16] <= 8'd4;
            mem[24] <= 8'd2;
            mem[25] <= 8'h55;
        end else if (bi.MemWrite && bi.Mem_Addr <= 64'd248) begin
            for (int i = 0; i < 8; i++) mem[8'(bi.Mem_Addr + 64'(i))] <= bi.Write_Data[8*i +: 8];
        end
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // Issue one request, then scramble req_* to prove the captured copy is used.
    task automatic run(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
        logic got;
        bi.req_valid = 1'b1; bi.req_write = w; bi.req_funct3 = f3; bi.req_addr = a; bi.req_wdata = d;
        @(posedge clk); #1;
        bi.req_valid = 1'b0; bi.req_write = ~w; bi.req_funct3 = ~f3; bi.req_addr = ~a; bi.req_wdata = ~d;
        lat = 0; rd_cyc = 0; wr_cyc = 0; wd = '0; ma = '0; rdata = 'x; flt = 1'bx; got = 1'b0;
        for (int c = 1; c <= 6 && !got; c++) begin
            if (bi.MemRead && rd_cyc == 0) begin rd_cyc = c; ma = bi.Mem_Addr; end
            if (bi.MemWrite && wr_cyc == 0) begin wr_cyc = c; wd = bi.Write_Data; end
            if (bi.resp_valid) begin
                got = 1'b1; lat = c; rdata = bi.resp_rdata; flt = bi.resp_fault;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (got) begin @(posedge clk); #1; end
        chk("ready_after_resp", {bi.req_ready, bi.resp_valid}, 2'b10);
    endtask
    task automatic load(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] exp, input string tag);
        run(1'b0, f3, a, 64'h0);
        chk(tag, rdata, exp);
        chk({tag, "_lat"}, 64'(lat), 64'd2);
    endtask
    initial begin
        bi.req_valid = 1'b0; bi.req_write = 1'b0; bi.req_funct3 = '0; bi.req_addr = '0; bi.req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        chk("rst_ready", bi.req_ready, 1'b1);
        chk("rst_resp", {bi.resp_valid, bi.resp_fault, bi.resp_rdata}, '0);
        chk("rst_mem", {bi.MemRead, bi.MemWrite, bi.Mem_Addr, bi.Write_Data}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(1'b0, 3'b011, 64'd0, 64'h0);
        chk("ld0_data", rdata, 64'd3);
        chk("ld0_lat", 64'(lat), 64'd2);
        chk("ld0_fault", flt, 1'b0);
        chk("ld0_rdcyc", 64'(rd_cyc), 64'd1);
        run(1'b1, 3'b000, 64'd8, 64'h1234_5678_9ABC_DEAB);
        chk("sb8_cycles", {32'(rd_cyc), 32'(wr_cyc)}, {32'd1, 32'd2});
        chk("sb8_lat", 64'(lat), 64'd3);
        chk("sb8_addr", ma, 64'd8);
        chk("sb8_wdata", wd, 64'h0000_0000_0000_00AB);
        chk("sb8_resp", {flt, rdata}, '0);
        chk("sb8_neigh", 64'(mem[9] | mem[10] | mem[11] | mem[12] | mem[13] | mem[14] | mem[15]), 64'd0);
        load(3'b011, 64'd8, 64'hAB, "ld8");
        run(1'b1, 3'b011, 64'd16, 64'h8000_0000_0000_0080);
        chk("sd16_lat", 64'(lat), 64'd2);
        chk("sd16_cycles", {32'(rd_cyc), 32'(wr_cyc)}, {32'd0, 32'd1});
        chk("sd16_wdata", wd, 64'h8000_0000_0000_0080);
        load(3'b000, 64'd16, 64'hFFFF_FFFF_FFFF_FF80, "lb16");
        load(3'b100, 64'd16, 64'h80, "lbu16");
        load(3'b011, 64'd16, 64'h8000_0000_0000_0080, "ld16");
        load(3'b001, 64'd16, 64'h80, "lh16");
        load(3'b010, 64'd20, 64'hFFFF_FFFF_8000_0000, "lw20");
        load(3'b110, 64'd20, 64'h0000_0000_8000_0000, "lwu20");
        run(1'b0, 3'b011, 64'd249, 64'h0);
        chk("ld249", {32'(lat), 32'(rd_cyc), 31'd0, flt, rdata}, {32'd1, 32'd0, 31'd0, 1'b1, 64'd0});
        run(1'b0, 3'b011, 64'd248, 64'h0);
        chk("ld248", {32'(lat), 31'd0, flt, rdata}, {32'd2, 31'd0, 1'b0, 64'd0});
        run(1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
        chk("ld_wrap", {32'(lat), 32'(rd_cyc), 31'd0, flt}, {32'd1, 32'd0, 31'd0, 1'b1});
        run(1'b1, 3'b110, 64'd0, 64'hDEAD_BEEF);
        chk("sw_f3_110", {32'(rd_cyc), 32'(wr_cyc), 31'd0, flt, rdata}, {64'd0, 31'd0, 1'b1, 64'd0});
        run(1'b0, 3'b111, 64'd0, 64'h0);
        chk("ld_f3_111", {32'(lat), 32'(rd_cyc), 31'd0, flt, rdata}, {32'd1, 32'd0, 31'd0, 1'b1, 64'd0});
        bi.req_valid = 1'b1; bi.req_write = 1'b1; bi.req_funct3 = 3'b001; bi.req_addr = 64'd0; bi.req_wdata = 64'hFFFF;
        @(posedge clk); #1;
        bi.req_valid = 1'b0;
        chk("abort_rmwrd", bi.MemRead, 1'b1);
        @(posedge clk); #1;
        chk("abort_rmwwr", {bi.MemWrite, bi.Write_Data}, {1'b1, 64'hFFFF});
        #2 rst_n = 1'b0;
        #1;
        chk("abort_async", {bi.MemRead, bi.MemWrite, bi.Mem_Addr, bi.Write_Data}, '0);
        chk("abort_ready", {bi.req_ready, bi.resp_valid, bi.resp_fault}, 3'b100);
        #8 rst_n = 1'b1;
        flt = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            flt = flt | bi.resp_valid;
        end
        chk("abort_noresp", flt, 1'b0);
        chk("abort_mem0", 64'(mem[0]), 64'd3);
        chk("abort_ready2", bi.req_ready, 1'b1);
        run(1'b1, 3'b001, 64'd1, 64'hBEEF);
        chk("sh1_wdata", wd, 64'hAB00_0000_0000_BEEF);
        load(3'b011, 64'd0, 64'h0000_0000_00BE_EF03, "ld0_after_sh");
        load(3'b001, 64'd1, 64'hFFFF_FFFF_FFFF_BEEF, "lh1");
        load(3'b101, 64'd1, 64'hBEEF, "lhu1");
        run(1'b1, 3'b000, 64'd24, 64'hCD);
        load(3'b011, 64'd24, 64'h55CD, "ld24_merge");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
